// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - key gesture classifier: single/double click, long press, auto-repeat
//
// Purpose:
//   Consumes the debounced key_flag/key_state pair from key_filter.
//   Classifies each key gesture and reports it as a one-cycle registered pulse.
//
// Ports:
//   Clk          in   system clock
//   Rst          in   synchronous reset, active-high
//   key_flag     in   one-cycle pulse on each debounced edge
//   key_state    in   debounced level (0 = pressed, 1 = released), valid with key_flag
//   single_click out  one-cycle pulse: press/release with no second press in time
//   double_click out  one-cycle pulse: second release of a quick press pair
//   long_press   out  one-cycle pulse when the hold threshold is reached
//   repeat_tick  out  one-cycle pulse every REPEAT_CNT cycles while held long
//   busy         out  high whenever a gesture is in progress (state != IDLE)

module key_event_decoder #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int DCLICK_CNT = 15_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_W      = 32
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_flag,
  input  logic key_state,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  // Terminal timer values: the action fires on the cycle the timer reads N-1.
  localparam logic [CNT_W-1:0] LONG_MAX   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_MAX = CNT_W'(DCLICK_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic             single_nxt;
  logic             double_nxt;
  logic             long_nxt;
  logic             repeat_nxt;
  logic             busy_nxt;

  logic press;
  logic release_ev;

  assign press      = key_flag & ~key_state;
  assign release_ev = key_flag &  key_state;

  // State, timer and all outputs are registered together so a condition
  // sampled on one edge shows up as a pulse for exactly the next cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      timer        <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      single_click <= single_nxt;
      double_click <= double_nxt;
      long_press   <= long_nxt;
      repeat_tick  <= repeat_nxt;
      busy         <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer + TIMER_ONE;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;

    // Key events are checked before timeouts in every state, so an event
    // landing on the same edge as a timeout suppresses the timeout action.
    case (state)
      IDLE: begin
        // A release here is spurious (e.g. after a reset mid-press).
        if (press) begin
          state_nxt = PRESS1;
        end
      end

      PRESS1: begin
        if (release_ev) begin
          state_nxt = WAIT2;
        end else if (timer == LONG_MAX) begin
          long_nxt  = 1'b1;
          state_nxt = HOLD;
        end
      end

      WAIT2: begin
        if (press) begin
          state_nxt = PRESS2;
        end else if (timer == DCLICK_MAX) begin
          single_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end

      PRESS2: begin
        // Holding the second press too long turns into a long press and
        // the pending double click is dropped.
        if (release_ev) begin
          double_nxt = 1'b1;
          state_nxt  = IDLE;
        end else if (timer == LONG_MAX) begin
          long_nxt  = 1'b1;
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        if (release_ev) begin
          state_nxt = IDLE;
        end else if (timer == REPEAT_MAX) begin
          repeat_nxt = 1'b1;
          timer_nxt  = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Timer restarts on every state entry; it is parked at zero in IDLE so
    // it can never run away while no gesture is active.
    if ((state_nxt != state) || (state_nxt == IDLE)) begin
      timer_nxt = '0;
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - scoreboard bench for key_event_decoder

module tb_key_event_decoder;

  localparam int LONG_CNT   = 100;
  localparam int DCLICK_CNT = 40;
  localparam int REPEAT_CNT = 20;

  localparam int K_SINGLE = 1;
  localparam int K_DOUBLE = 2;
  localparam int K_LONG   = 3;
  localparam int K_REPEAT = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic single_click, double_click, long_press, repeat_tick, busy;

  key_event_decoder #(
    .LONG_CNT  (LONG_CNT),
    .DCLICK_CNT(DCLICK_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .CNT_W     (32)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .key_flag    (key_flag),
    .key_state   (key_state),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  // cyc = number of rising edges so far; a pulse caused by the condition
  // sampled at edge k is observed at the falling edge where cyc == k.
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: pops the scoreboard whenever any pulse output is high.
  int   mon_kind;
  int   mon_hot;
  exp_t mon_e;
  always @(negedge Clk) begin
    mon_hot = int'(single_click === 1'b1) + int'(double_click === 1'b1)
            + int'(long_press === 1'b1) + int'(repeat_tick === 1'b1);
    if (mon_hot > 0) begin
      mon_kind = (single_click === 1'b1) ? K_SINGLE :
                 (double_click === 1'b1) ? K_DOUBLE :
                 (long_press   === 1'b1) ? K_LONG   : K_REPEAT;
      n_cmp++;
      if (mon_hot > 1) begin
        n_bad++;
        $display("FAIL pulse_exclusive: %0d pulses high at cyc %0d, required 1", mon_hot, cyc);
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: kind %0d at cyc %0d, required none", mon_kind, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != mon_kind || mon_e.cyc != cyc) begin
          n_bad++;
          $display("FAIL pulse: kind %0d at cyc %0d, required kind %0d at cyc %0d",
                   mon_kind, cyc, mon_e.kind, mon_e.cyc);
        end
      end
    end
  end

  task automatic expect_pulse(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge Clk);
  endtask

  // Drive a one-cycle key_flag so it is sampled at rising edge e.
  task automatic ev_at(input logic st, input int e);
    wait_cyc(e - 1);
    key_flag  = 1'b1;
    key_state = st;
    @(negedge Clk);
    key_flag  = 1'b0;
    key_state = 1'b1;
  endtask

  task automatic chk_quiet(input string name);
    chk(name, int'({single_click, double_click, long_press, repeat_tick, busy}), 0);
  endtask

  int t;

  initial begin
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk_quiet("reset_state");

    // Single click: single_click 40 cycles after the release edge.
    t = cyc + 5;
    expect_pulse(K_SINGLE, t + 50);
    wait_cyc(t - 1);
    chk("sc_busy_before", int'(busy), 0);
    ev_at(1'b0, t);
    chk("sc_busy_after_press", int'(busy), 1);
    ev_at(1'b1, t + 10);
    wait_cyc(t + 49);
    chk("sc_busy_hold", int'(busy), 1);
    wait_cyc(t + 50);
    chk("sc_busy_drop", int'(busy), 0);

    // Double click.
    t = cyc + 5;
    expect_pulse(K_DOUBLE, t + 45);
    ev_at(1'b0, t);
    ev_at(1'b1, t + 10);
    ev_at(1'b0, t + 30);
    wait_cyc(t + 44);
    chk("dc_busy_hold", int'(busy), 1);
    ev_at(1'b1, t + 45);
    chk("dc_busy_drop", int'(busy), 0);
    wait_cyc(t + 100);

    // Long press with four repeat ticks, then a silent release.
    t = cyc + 5;
    expect_pulse(K_LONG, t + 100);
    for (int i = 1; i <= 4; i++) expect_pulse(K_REPEAT, t + 100 + i * REPEAT_CNT);
    ev_at(1'b0, t);
    wait_cyc(t + 199);
    chk("lp_busy_hold", int'(busy), 1);
    ev_at(1'b1, t + 200);
    chk("lp_busy_drop", int'(busy), 0);
    wait_cyc(t + 260);

    // Release on the same edge as the long-press timeout: single click path.
    t = cyc + 5;
    expect_pulse(K_SINGLE, t + 140);
    ev_at(1'b0, t);
    ev_at(1'b1, t + 100);
    wait_cyc(t + 140);
    chk("bnd_long_busy_drop", int'(busy), 0);
    wait_cyc(t + 200);

    // Second press on the same edge as the double-click timeout.
    t = cyc + 5;
    expect_pulse(K_DOUBLE, t + 55);
    ev_at(1'b0, t);
    ev_at(1'b1, t + 10);
    ev_at(1'b0, t + 50);
    chk("bnd_dclick_busy", int'(busy), 1);
    ev_at(1'b1, t + 55);
    wait_cyc(t + 120);

    // Second press held past the long threshold: long press, no double click.
    t = cyc + 5;
    expect_pulse(K_LONG, t + 120);
    expect_pulse(K_REPEAT, t + 140);
    ev_at(1'b0, t);
    ev_at(1'b1, t + 10);
    ev_at(1'b0, t + 20);
    ev_at(1'b1, t + 150);
    chk("p2_long_busy_drop", int'(busy), 0);
    wait_cyc(t + 200);

    // Reset while in WAIT2 aborts the gesture with no pulse.
    t = cyc + 5;
    ev_at(1'b0, t);
    ev_at(1'b1, t + 10);
    wait_cyc(t + 19);
    chk("rst_busy_before", int'(busy), 1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk_quiet("rst_mid_gesture");
    wait_cyc(t + 80);
    chk_quiet("rst_no_late_click");

    // Spurious release in IDLE.
    t = cyc + 5;
    ev_at(1'b1, t);
    chk_quiet("spurious_release");
    wait_cyc(t + 60);
    chk_quiet("spurious_release_late");

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete by cyc %0d, required completion", cyc);
    $fatal(1);
  end

endmodule
